// File: rtl/dmi_transport_ctrl.sv
// DTM-side DMI transport: turns TAP dmi/dtmcs updates into a valid/ready request
// to the debug module, tracks the response, and keeps the sticky dmistat error.
module dmi_transport_ctrl #(
  parameter int ABITS          = 7,
  parameter int DATA_W         = 32,
  parameter int IDLE_HINT      = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    dtmcs_update,
  input  logic [31:0]             dtmcs_wdata,
  output logic [31:0]             dtmcs_rdata,
  input  logic                    dmi_update,
  input  logic [ABITS+DATA_W+1:0] dmi_wdata,
  output logic [ABITS+DATA_W+1:0] dmi_rdata,
  output logic                    dm_req_valid,
  input  logic                    dm_req_ready,
  output logic [ABITS-1:0]        dm_req_addr,
  output logic [DATA_W-1:0]       dm_req_data,
  output logic                    dm_req_write,
  input  logic                    dm_rsp_valid,
  input  logic [DATA_W-1:0]       dm_rsp_data,
  input  logic [1:0]              dm_rsp_status,
  output logic                    dm_hard_reset,
  output logic                    busy
);

  localparam int DMI_W = ABITS + DATA_W + 2;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [1:0] STICKY_OK     = 2'd0;
  localparam logic [1:0] STICKY_FAILED = 2'd2;
  localparam logic [1:0] STICKY_BUSY   = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd1;
  localparam logic [1:0] OP_WRITE = 2'd2;

  localparam logic [2:0] IDLE_FIELD  = (IDLE_HINT > 7) ? 3'd7 : 3'(IDLE_HINT);
  localparam logic [5:0] ABITS_FIELD = 6'(ABITS);

  logic [1:0]        state_reg, state_next;
  logic [1:0]        sticky_reg, sticky_next;
  logic [ABITS-1:0]  addr_reg, addr_next;
  logic [DATA_W-1:0] data_reg, data_next;
  logic              write_reg, write_next;
  logic [31:0]       cnt_reg, cnt_next;
  logic              hard_reset_reg, hard_reset_next;

  logic [1:0]        dmi_op;
  logic [DATA_W-1:0] dmi_data;
  logic [ABITS-1:0]  dmi_addr;
  logic              dmireset;
  logic              dmihardreset;
  logic              timeout_hit;
  logic [1:0]        status;
  logic              unused_dtmcs_bits;

  assign dmi_op       = dmi_wdata[1:0];
  assign dmi_data     = dmi_wdata[DATA_W+1:2];
  assign dmi_addr     = dmi_wdata[DMI_W-1:DATA_W+2];
  assign dmireset     = dtmcs_update & dtmcs_wdata[16];
  assign dmihardreset = dtmcs_update & dtmcs_wdata[17];
  assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (cnt_reg == 32'(TIMEOUT_CYCLES - 1));
  assign unused_dtmcs_bits = ^{dtmcs_wdata[31:18], dtmcs_wdata[15:0]};

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    data_next       = data_reg;
    write_next      = write_reg;
    cnt_next        = cnt_reg;
    hard_reset_next = 1'b0;
    // dmireset clears first so a same-cycle dmi update sees the cleared sticky
    sticky_next     = dmireset ? STICKY_OK : sticky_reg;

    if (dmihardreset) begin
      state_next      = ST_IDLE;
      sticky_next     = STICKY_OK;
      hard_reset_next = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (dmi_update && sticky_next == STICKY_OK &&
              (dmi_op == OP_READ || dmi_op == OP_WRITE)) begin
            addr_next  = dmi_addr;
            write_next = (dmi_op == OP_WRITE);
            if (dmi_op == OP_WRITE) data_next = dmi_data;
            state_next = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (dm_req_ready) begin
            state_next = ST_WAIT;
            cnt_next   = '0;
          end
        end
        ST_WAIT: begin
          if (dm_rsp_valid) begin
            if (!write_reg) data_next = dm_rsp_data;
            if (dm_rsp_status != 2'd0 && sticky_next == STICKY_OK) sticky_next = STICKY_FAILED;
            state_next = ST_IDLE;
          end else if (timeout_hit) begin
            if (sticky_next == STICKY_OK) sticky_next = STICKY_FAILED;
            state_next = ST_DRAIN;
          end else begin
            cnt_next = cnt_reg + 32'd1;
          end
        end
        ST_DRAIN: begin
          if (dm_rsp_valid) state_next = ST_IDLE;
        end
        default: state_next = ST_IDLE;
      endcase

      // Evaluated after the response so a failing response is the error that sticks
      if (state_reg != ST_IDLE && dmi_update && sticky_next == STICKY_OK)
        sticky_next = STICKY_BUSY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= ST_IDLE;
      sticky_reg     <= STICKY_OK;
      addr_reg       <= '0;
      data_reg       <= '0;
      write_reg      <= 1'b0;
      cnt_reg        <= '0;
      hard_reset_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sticky_reg     <= sticky_next;
      addr_reg       <= addr_next;
      data_reg       <= data_next;
      write_reg      <= write_next;
      cnt_reg        <= cnt_next;
      hard_reset_reg <= hard_reset_next;
    end
  end

  assign status = (sticky_reg != STICKY_OK) ? sticky_reg :
                  (state_reg != ST_IDLE)    ? 2'd3 : 2'd0;

  assign dmi_rdata     = {addr_reg, data_reg, status};
  assign dtmcs_rdata   = {17'b0, IDLE_FIELD, status, ABITS_FIELD, 4'd1};
  assign dm_req_valid  = (state_reg == ST_ISSUE);
  assign dm_req_addr   = addr_reg;
  assign dm_req_data   = data_reg;
  assign dm_req_write  = write_reg;
  assign dm_hard_reset = hard_reset_reg;
  assign busy          = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_dmi_transport_ctrl.sv
// Bench for dmi_transport_ctrl: vector table, directed corner sequences and
// randomized transactions checked against a transaction-level sticky/data model.
module tb_dmi_transport_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: ABITS=7, DATA_W=32, short timeout
  logic        a_dtmcs_update, a_dmi_update, a_req_valid, a_req_ready, a_req_write;
  logic        a_rsp_valid, a_hard_reset, a_busy;
  logic [31:0] a_dtmcs_wdata, a_dtmcs_rdata, a_req_data, a_rsp_data;
  logic [40:0] a_dmi_wdata, a_dmi_rdata;
  logic [6:0]  a_req_addr;
  logic [1:0]  a_rsp_status;

  dmi_transport_ctrl #(.ABITS(7), .DATA_W(32), .IDLE_HINT(5), .TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset(reset),
    .dtmcs_update(a_dtmcs_update), .dtmcs_wdata(a_dtmcs_wdata), .dtmcs_rdata(a_dtmcs_rdata),
    .dmi_update(a_dmi_update), .dmi_wdata(a_dmi_wdata), .dmi_rdata(a_dmi_rdata),
    .dm_req_valid(a_req_valid), .dm_req_ready(a_req_ready), .dm_req_addr(a_req_addr),
    .dm_req_data(a_req_data), .dm_req_write(a_req_write),
    .dm_rsp_valid(a_rsp_valid), .dm_rsp_data(a_rsp_data), .dm_rsp_status(a_rsp_status),
    .dm_hard_reset(a_hard_reset), .busy(a_busy)
  );

  // Instance B: wide configuration
  logic        b_dtmcs_update, b_dmi_update, b_req_valid, b_req_ready, b_req_write;
  logic        b_rsp_valid, b_hard_reset, b_busy;
  logic [31:0] b_dtmcs_wdata, b_dtmcs_rdata;
  logic [63:0] b_req_data, b_rsp_data;
  logic [77:0] b_dmi_wdata, b_dmi_rdata;
  logic [11:0] b_req_addr;
  logic [1:0]  b_rsp_status;

  dmi_transport_ctrl #(.ABITS(12), .DATA_W(64), .IDLE_HINT(9), .TIMEOUT_CYCLES(1024)) dut_b (
    .clk(clk), .reset(reset),
    .dtmcs_update(b_dtmcs_update), .dtmcs_wdata(b_dtmcs_wdata), .dtmcs_rdata(b_dtmcs_rdata),
    .dmi_update(b_dmi_update), .dmi_wdata(b_dmi_wdata), .dmi_rdata(b_dmi_rdata),
    .dm_req_valid(b_req_valid), .dm_req_ready(b_req_ready), .dm_req_addr(b_req_addr),
    .dm_req_data(b_req_data), .dm_req_write(b_req_write),
    .dm_rsp_valid(b_rsp_valid), .dm_rsp_data(b_rsp_data), .dm_rsp_status(b_rsp_status),
    .dm_hard_reset(b_hard_reset), .busy(b_busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] data;
    int          rdy;
    int          rspd;
    logic [1:0]  st;
    logic [31:0] rdat;
    bit          issue;
    logic [6:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_st;
  } vec_t;

  vec_t tbl [6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic a_dmi(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data);
    a_dmi_wdata  = {addr, data, op};
    a_dmi_update = 1'b1;
    step();
    a_dmi_update = 1'b0;
  endtask

  task automatic a_dtmcs(input logic [31:0] v);
    a_dtmcs_wdata  = v;
    a_dtmcs_update = 1'b1;
    step();
    a_dtmcs_update = 1'b0;
  endtask

  task automatic a_handshake();
    a_req_ready = 1'b1;
    step();
    a_req_ready = 1'b0;
  endtask

  // One full DMI transaction on instance A; optional same-cycle dmireset and extra dmi update
  task automatic a_txn(input logic [1:0] op, input logic [6:0] addr, input logic [31:0] data,
                       input int rdy, input int rspd, input logic [1:0] st,
                       input logic [31:0] rdat, input bit exp_issue, input bit extra,
                       input bit clr);
    a_dmi_wdata    = {addr, data, op};
    a_dmi_update   = 1'b1;
    a_dtmcs_wdata  = 32'h0001_0000;
    a_dtmcs_update = clr;
    step();
    a_dmi_update   = 1'b0;
    a_dtmcs_update = 1'b0;
    chk("req_valid", a_req_valid, exp_issue);
    if (!exp_issue) begin
      chk("busy_noissue", a_busy, 1'b0);
    end else begin
      for (int i = 0; i < rdy; i++) begin
        step();
        chk("req_held", a_req_valid, 1'b1);
      end
      chk("req_addr", a_req_addr, addr);
      chk("req_write", a_req_write, op == 2'd2);
      if (op == 2'd2) chk("req_data", a_req_data, data);
      a_handshake();
      chk("req_drop", a_req_valid, 1'b0);
      chk("busy_wait", a_busy, 1'b1);
      for (int i = 0; i < rspd; i++) begin
        if (extra && i == 0) a_dmi(2'd1, ~addr, 32'h0);
        else step();
      end
      a_rsp_valid  = 1'b1;
      a_rsp_data   = rdat;
      a_rsp_status = st;
      if (extra && rspd == 0) begin
        a_dmi_wdata  = {~addr, 32'h0, 2'd1};
        a_dmi_update = 1'b1;
      end
      step();
      a_rsp_valid  = 1'b0;
      a_dmi_update = 1'b0;
      chk("busy_done", a_busy, 1'b0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [6:0]  m_addr, r_addr;
    logic [31:0] m_data, r_data, r_rdat;
    logic [1:0]  m_sticky, r_op, r_st;
    int          r_rdy, r_rspd;
    bit          r_extra, r_clr, r_issue;

    tbl[0] = '{2'd2, 7'h10, 32'hDEADBEEF, 2, 1, 2'd0, 32'h0,        1'b1, 7'h10, 32'hDEADBEEF, 2'd0};
    tbl[1] = '{2'd1, 7'h11, 32'h0,        0, 2, 2'd0, 32'h12345678, 1'b1, 7'h11, 32'h12345678, 2'd0};
    tbl[2] = '{2'd0, 7'h55, 32'hFFFFFFFF, 0, 0, 2'd0, 32'h0,        1'b0, 7'h11, 32'h12345678, 2'd0};
    tbl[3] = '{2'd3, 7'h7F, 32'hAAAA5555, 0, 0, 2'd0, 32'h0,        1'b0, 7'h11, 32'h12345678, 2'd0};
    tbl[4] = '{2'd2, 7'h22, 32'h0BADF00D, 1, 0, 2'd2, 32'h0,        1'b1, 7'h22, 32'h0BADF00D, 2'd2};
    tbl[5] = '{2'd1, 7'h33, 32'h0,        0, 0, 2'd0, 32'h11111111, 1'b0, 7'h22, 32'h0BADF00D, 2'd2};

    reset = 1'b1;
    {a_dtmcs_update, a_dmi_update, a_req_ready, a_rsp_valid} = '0;
    a_dtmcs_wdata = '0; a_dmi_wdata = '0; a_rsp_data = '0; a_rsp_status = '0;
    {b_dtmcs_update, b_dmi_update, b_req_ready, b_rsp_valid} = '0;
    b_dtmcs_wdata = '0; b_dmi_wdata = '0; b_rsp_data = '0; b_rsp_status = '0;
    step();
    step();
    reset = 1'b0;

    chk("rst_dmi_rdata", a_dmi_rdata, 41'h0);
    chk("rst_dtmcs", a_dtmcs_rdata, 32'h0000_5071);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_req_valid", a_req_valid, 1'b0);
    chk("rst_hard_reset", a_hard_reset, 1'b0);

    foreach (tbl[k]) begin
      a_txn(tbl[k].op, tbl[k].addr, tbl[k].data, tbl[k].rdy, tbl[k].rspd, tbl[k].st,
            tbl[k].rdat, tbl[k].issue, 1'b0, 1'b0);
      chk("tbl_rdata", a_dmi_rdata, {tbl[k].e_addr, tbl[k].e_data, tbl[k].e_st});
      $display("vector %0d op=%0d addr=%0h rdata=%0h", k, tbl[k].op, tbl[k].addr, a_dmi_rdata);
    end
    chk("dtmcs_failed", a_dtmcs_rdata, 32'h0000_5871);
    a_dtmcs(32'h0001_0000);
    chk("dmireset_clear", a_dtmcs_rdata, 32'h0000_5071);

    // Second update during WAIT -> sticky BUSY, later writes ignored until dmireset
    a_dmi(2'd2, 7'h40, 32'hCAFE0001);
    a_handshake();
    a_dmi(2'd2, 7'h41, 32'h0);
    chk("busy_no_second_req", a_req_valid, 1'b0);
    chk("busy_status_wait", a_dmi_rdata[1:0], 2'd3);
    step();
    a_rsp_valid = 1'b1; a_rsp_status = 2'd0;
    step();
    a_rsp_valid = 1'b0;
    chk("busy_after_done", a_busy, 1'b0);
    chk("busy_status_done", a_dtmcs_rdata, 32'h0000_5C71);
    a_dmi(2'd2, 7'h42, 32'h1);
    chk("busy_write_ignored", a_req_valid, 1'b0);
    chk("busy_rdata_kept", a_dmi_rdata, {7'h40, 32'hCAFE0001, 2'd3});
    a_dtmcs(32'h0001_0000);
    a_txn(2'd2, 7'h43, 32'h77777777, 0, 0, 2'd0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("busy_recovered", a_dmi_rdata, {7'h43, 32'h77777777, 2'd0});
    $display("busy sequence rdata=%0h", a_dmi_rdata);

    // Timeout after 8 WAIT cycles, late response drained
    a_dmi(2'd1, 7'h50, 32'h0);
    a_handshake();
    for (int i = 0; i < 7; i++) step();
    chk("to_before", a_dmi_rdata[1:0], 2'd3);
    step();
    chk("to_failed", a_dmi_rdata[1:0], 2'd2);
    chk("to_drain_busy", a_busy, 1'b1);
    for (int i = 0; i < 11; i++) step();
    chk("to_still_drain", a_busy, 1'b1);
    a_rsp_valid = 1'b1; a_rsp_data = 32'hBAD0BAD0; a_rsp_status = 2'd0;
    step();
    a_rsp_valid = 1'b0;
    chk("to_idle", a_busy, 1'b0);
    chk("to_discard", a_dmi_rdata, {7'h50, 32'h77777777, 2'd2});
    $display("timeout sequence rdata=%0h", a_dmi_rdata);
    a_dtmcs(32'h0001_0000);

    // dmihardreset during WAIT
    a_dmi(2'd1, 7'h60, 32'h0);
    a_handshake();
    step();
    a_dtmcs(32'h0002_0000);
    chk("hr_pulse", a_hard_reset, 1'b1);
    chk("hr_busy", a_busy, 1'b0);
    chk("hr_status", a_dmi_rdata[1:0], 2'd0);
    step();
    chk("hr_pulse_end", a_hard_reset, 1'b0);
    a_dmi_wdata = {7'h62, 32'h0, 2'd1}; a_dmi_update = 1'b1;
    a_dtmcs_wdata = 32'h0002_0000; a_dtmcs_update = 1'b1;
    step();
    a_dmi_update = 1'b0; a_dtmcs_update = 1'b0;
    chk("hr_drops_update", a_req_valid, 1'b0);
    a_txn(2'd1, 7'h61, 32'h0, 0, 1, 2'd0, 32'h61616161, 1'b1, 1'b0, 1'b0);
    chk("hr_new_read", a_dmi_rdata, {7'h61, 32'h61616161, 2'd0});
    $display("hardreset sequence rdata=%0h", a_dmi_rdata);

    // Randomized transactions against the sticky/data model
    reset = 1'b1;
    step();
    reset = 1'b0;
    m_addr = '0; m_data = '0; m_sticky = 2'd0;
    for (int n = 0; n < 60; n++) begin
      r_op    = 2'($urandom_range(0, 3));
      r_addr  = 7'($urandom);
      r_data  = $urandom;
      r_rdy   = int'($urandom_range(0, 3));
      r_rspd  = int'($urandom_range(0, 4));
      r_st    = ($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0;
      r_rdat  = $urandom;
      r_extra = ($urandom_range(0, 3) == 0);
      r_clr   = (m_sticky != 2'd0) && ($urandom_range(0, 1) == 1);
      if (r_clr) m_sticky = 2'd0;
      r_issue = (r_op == 2'd1 || r_op == 2'd2) && m_sticky == 2'd0;
      if (r_issue) begin
        m_addr = r_addr;
        if (r_op == 2'd2) m_data = r_data;
        else m_data = r_rdat;
        if (r_extra && r_rspd > 0) m_sticky = 2'd3;
        if (r_st != 2'd0 && m_sticky == 2'd0) m_sticky = 2'd2;
        if (r_extra && r_rspd == 0 && m_sticky == 2'd0) m_sticky = 2'd3;
      end
      a_txn(r_op, r_addr, r_data, r_rdy, r_rspd, r_st, r_rdat, r_issue, r_extra, r_clr);
      chk("rand_rdata", a_dmi_rdata, {m_addr, m_data, m_sticky});
      $display("rand %0d op=%0d issue=%0d rdata=%0h", n, r_op, r_issue, a_dmi_rdata);
    end

    // Reset in the middle of a transaction
    a_dtmcs(32'h0001_0000);
    a_dmi(2'd2, 7'h70, 32'h12341234);
    chk("mid_rst_issue", a_req_valid, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_valid", a_req_valid, 1'b0);
    chk("mid_rst_rdata", a_dmi_rdata, 41'h0);
    chk("mid_rst_req", {a_req_addr, a_req_data, a_req_write}, 40'h0);
    chk("mid_rst_no_pulse", a_hard_reset, 1'b0);
    $display("mid-transaction reset busy=%0d", a_busy);

    // Wide configuration
    chk("b_dtmcs", b_dtmcs_rdata, 32'h0000_70C1);
    b_dmi_wdata = {12'hABC, 64'h0123456789ABCDEF, 2'd2}; b_dmi_update = 1'b1;
    step();
    b_dmi_update = 1'b0;
    chk("b_req", {b_req_valid, b_req_write, b_req_addr, b_req_data},
        {1'b1, 1'b1, 12'hABC, 64'h0123456789ABCDEF});
    b_req_ready = 1'b1; step(); b_req_ready = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_status = 2'd0; step(); b_rsp_valid = 1'b0;
    chk("b_write_rdata", b_dmi_rdata, {12'hABC, 64'h0123456789ABCDEF, 2'd0});
    b_dmi_wdata = {12'h5A5, 64'h0, 2'd1}; b_dmi_update = 1'b1;
    step();
    b_dmi_update = 1'b0;
    chk("b_read_req", {b_req_valid, b_req_write, b_req_addr}, {1'b1, 1'b0, 12'h5A5});
    b_req_ready = 1'b1; step(); b_req_ready = 1'b0;
    b_rsp_valid = 1'b1; b_rsp_data = 64'hFEDCBA9876543210; step(); b_rsp_valid = 1'b0;
    chk("b_read_rdata", b_dmi_rdata, {12'h5A5, 64'hFEDCBA9876543210, 2'd0});
    chk("b_busy", b_busy, 1'b0);
    $display("wide config rdata=%0h", b_dmi_rdata);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
